// File: rtl/bt_vga_screen_if.sv
// bt_vga_screen_if: serial input line plus VGA and receive-status outputs of bt_vga_screen.
// master = the screen block (drives video/status), slave = whoever observes it.
interface bt_vga_screen_if #(
  parameter int COLOR_W = 4
);
  logic               get_bluetooth;
  logic               x_valid;
  logic               y_valid;
  logic [COLOR_W-1:0] red_out;
  logic [COLOR_W-1:0] green_out;
  logic [COLOR_W-1:0] blue_out;
  logic [7:0]         bt;
  logic               rx_valid;
  logic               rx_err;
  logic               frame_start;

  modport master (
    input  get_bluetooth,
    output x_valid, y_valid, red_out, green_out, blue_out,
    output bt, rx_valid, rx_err, frame_start
  );

  modport slave (
    output get_bluetooth,
    input  x_valid, y_valid, red_out, green_out, blue_out,
    input  bt, rx_valid, rx_err, frame_start
  );
endinterface

// File: rtl/bt_vga_screen.sv
// bt_vga_screen: UART command receiver feeding a parametrised VGA timing and
// test-pattern generator. A received byte becomes the pending command and is
// only made active at the frame wrap, so a frame is never drawn half-and-half.
// Optional build macro BT_RX_PARITY_EN: adds an even-parity bit after the data
// bits (8E1); a parity mismatch discards the byte and pulses rx_err.
module bt_vga_screen #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int PIX_DIV      = 4,
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int SYNC_POL     = 0,
  parameter int COLOR_W      = 4,
  parameter int CHECK_LOG2   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  bt_vga_screen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // counters are wide enough to hold the total and the checkerboard select bit
  localparam int HW = ($clog2(H_TOTAL) > CHECK_LOG2) ? $clog2(H_TOTAL) : CHECK_LOG2 + 1;
  localparam int VW = ($clog2(V_TOTAL) > CHECK_LOG2) ? $clog2(V_TOTAL) : CHECK_LOG2 + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int H_BAR = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam int V_BAR = (V_ACTIVE >= 8) ? V_ACTIVE / 8 : 1;
  localparam logic SYNC_ON = (SYNC_POL != 0) ? 1'b1 : 1'b0;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [DW-1:0] DIV_M1  = DW'(PIX_DIV - 1);

`ifdef BT_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4
  } rx_state_t;

  // even parity: data bits plus parity bit must XOR to zero
  function automatic logic even_parity_ok(input logic [7:0] d, input logic p);
    return ~(^{d, p});
  endfunction
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd4
  } rx_state_t;
`endif

  rx_state_t state_r, state_nx;
  logic          rx_meta_r, rx_sync_r, rx_prev_r;
  logic [CW-1:0] clk_cnt_r, clk_cnt_nx;
  logic [2:0]    bit_cnt_r, bit_cnt_nx;
  logic [7:0]    shift_r, shift_nx;
  logic          byte_ok_s, byte_bad_s, stop_ok_s;
  logic [7:0]    bt_r;
  logic          rx_valid_r, rx_err_r;
`ifdef BT_RX_PARITY_EN
  logic          par_bad_r, par_bad_nx;
`endif

  logic [DW-1:0] div_cnt_r;
  logic          pix_ce_s;
  logic [HW-1:0] h_cnt_r, h_bar_s;
  logic [VW-1:0] v_cnt_r, v_bar_s;
  logic          h_last_s, v_last_s, frame_wrap_s;
  logic [4:0]    pend_r, cmd_r;
  logic          pend_flag_r;
  logic          frame_start_r;

  logic [2:0]    h_idx_s, v_idx_s, col_s;
  logic          active_s, hsync_s, vsync_s;
  logic          x_valid_r, y_valid_r;
  logic [COLOR_W-1:0] red_r, green_r, blue_r;

  // two-flop synchroniser on the serial line plus a delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= vga.get_bluetooth;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

`ifdef BT_RX_PARITY_EN
  assign stop_ok_s = rx_sync_r & ~par_bad_r;
`else
  assign stop_ok_s = rx_sync_r;
`endif

  // receiver next-state: bit timing, data shifting and frame accept/reject decision
  always_comb begin
    state_nx   = state_r;
    clk_cnt_nx = clk_cnt_r + CW'(1);
    bit_cnt_nx = bit_cnt_r;
    shift_nx   = shift_r;
    byte_ok_s  = 1'b0;
    byte_bad_s = 1'b0;
`ifdef BT_RX_PARITY_EN
    par_bad_nx = par_bad_r;
`endif
    case (state_r)
      S_IDLE: begin
        clk_cnt_nx = {CW{1'b0}};
        bit_cnt_nx = 3'd0;
        if (rx_prev_r && !rx_sync_r) begin
          state_nx = S_START;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_START: begin
        if (clk_cnt_r == HALF_M1) begin
          clk_cnt_nx = {CW{1'b0}};
          // line back high at mid start bit: treat as a glitch, silently
          if (rx_sync_r) begin
            state_nx = S_IDLE;
          end else begin
            state_nx = S_DATA;
          end
        end else begin
          state_nx = S_START;
        end
      end
      S_DATA: begin
        if (clk_cnt_r == BIT_M1) begin
          clk_cnt_nx = {CW{1'b0}};
          shift_nx   = {rx_sync_r, shift_r[7:1]};
          bit_cnt_nx = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
`ifdef BT_RX_PARITY_EN
            state_nx = S_PARITY;
`else
            state_nx = S_STOP;
`endif
          end else begin
            state_nx = S_DATA;
          end
        end else begin
          state_nx = S_DATA;
        end
      end
`ifdef BT_RX_PARITY_EN
      S_PARITY: begin
        if (clk_cnt_r == BIT_M1) begin
          clk_cnt_nx = {CW{1'b0}};
          par_bad_nx = ~even_parity_ok(shift_r, rx_sync_r);
          state_nx   = S_STOP;
        end else begin
          state_nx = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        if (clk_cnt_r == BIT_M1) begin
          clk_cnt_nx = {CW{1'b0}};
          state_nx   = S_IDLE;
          if (stop_ok_s) begin
            byte_ok_s = 1'b1;
          end else begin
            byte_bad_s = 1'b1;
          end
        end else begin
          state_nx = S_STOP;
        end
      end
      default: begin
        state_nx   = S_IDLE;
        clk_cnt_nx = {CW{1'b0}};
        bit_cnt_nx = 3'd0;
      end
    endcase
  end

  // receiver state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      clk_cnt_r <= {CW{1'b0}};
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
`ifdef BT_RX_PARITY_EN
      par_bad_r <= 1'b0;
`endif
    end else begin
      state_r   <= state_nx;
      clk_cnt_r <= clk_cnt_nx;
      bit_cnt_r <= bit_cnt_nx;
      shift_r   <= shift_nx;
`ifdef BT_RX_PARITY_EN
      par_bad_r <= par_bad_nx;
`endif
    end
  end

  // received-byte output and one-clock status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bt_r       <= 8'h00;
      rx_valid_r <= 1'b0;
      rx_err_r   <= 1'b0;
    end else begin
      rx_valid_r <= byte_ok_s;
      rx_err_r   <= byte_bad_s;
      if (byte_ok_s) begin
        bt_r <= shift_r;
      end
    end
  end

  assign pix_ce_s     = (div_cnt_r == DIV_M1);
  assign h_last_s     = (h_cnt_r == HW'(H_TOTAL - 1));
  assign v_last_s     = (v_cnt_r == VW'(V_TOTAL - 1));
  assign frame_wrap_s = pix_ce_s & h_last_s & v_last_s;

  // pixel clock-enable divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= {DW{1'b0}};
    end else if (pix_ce_s) begin
      div_cnt_r <= {DW{1'b0}};
    end else begin
      div_cnt_r <= div_cnt_r + DW'(1);
    end
  end

  // horizontal / vertical raster counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_r <= {HW{1'b0}};
      v_cnt_r <= {VW{1'b0}};
    end else if (pix_ce_s) begin
      if (h_last_s) begin
        h_cnt_r <= {HW{1'b0}};
        if (v_last_s) begin
          v_cnt_r <= {VW{1'b0}};
        end else begin
          v_cnt_r <= v_cnt_r + VW'(1);
        end
      end else begin
        h_cnt_r <= h_cnt_r + HW'(1);
      end
    end
  end

  // pending/active command: a byte landing on the wrap clock waits for the next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r        <= 5'd0;
      pend_flag_r   <= 1'b0;
      cmd_r         <= 5'd0;
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= frame_wrap_s;
      if (frame_wrap_s && pend_flag_r) begin
        cmd_r <= pend_r;
      end
      if (byte_ok_s) begin
        pend_r      <= shift_r[4:0];
        pend_flag_r <= 1'b1;
      end else if (frame_wrap_s) begin
        pend_flag_r <= 1'b0;
      end
    end
  end

  // pattern colour and sync decode for the current counter position
  always_comb begin
    h_bar_s  = h_cnt_r / HW'(H_BAR);
    v_bar_s  = v_cnt_r / VW'(V_BAR);
    h_idx_s  = 3'd7;
    v_idx_s  = 3'd7;
    col_s    = 3'b000;
    if (h_bar_s > HW'(7)) begin
      h_idx_s = 3'd7;
    end else begin
      h_idx_s = h_bar_s[2:0];
    end
    if (v_bar_s > VW'(7)) begin
      v_idx_s = 3'd7;
    end else begin
      v_idx_s = v_bar_s[2:0];
    end
    case (cmd_r[1:0])
      2'd0: col_s = cmd_r[4:2];
      2'd1: col_s = h_idx_s;
      2'd2: col_s = v_idx_s;
      2'd3: begin
        if (h_cnt_r[CHECK_LOG2] ^ v_cnt_r[CHECK_LOG2]) begin
          col_s = cmd_r[4:2];
        end else begin
          col_s = 3'b000;
        end
      end
      default: col_s = 3'b000;
    endcase
    active_s = (h_cnt_r < HW'(H_ACTIVE)) && (v_cnt_r < VW'(V_ACTIVE));
    hsync_s  = (h_cnt_r >= HW'(H_ACTIVE + H_FP)) && (h_cnt_r < HW'(H_ACTIVE + H_FP + H_SYNC));
    vsync_s  = (v_cnt_r >= VW'(V_ACTIVE + V_FP)) && (v_cnt_r < VW'(V_ACTIVE + V_FP + V_SYNC));
  end

  // video outputs registered together so sync and colour stay aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_valid_r <= ~SYNC_ON;
      y_valid_r <= ~SYNC_ON;
      red_r     <= {COLOR_W{1'b0}};
      green_r   <= {COLOR_W{1'b0}};
      blue_r    <= {COLOR_W{1'b0}};
    end else if (pix_ce_s) begin
      x_valid_r <= hsync_s ? SYNC_ON : ~SYNC_ON;
      y_valid_r <= vsync_s ? SYNC_ON : ~SYNC_ON;
      red_r     <= (active_s && col_s[2]) ? {COLOR_W{1'b1}} : {COLOR_W{1'b0}};
      green_r   <= (active_s && col_s[1]) ? {COLOR_W{1'b1}} : {COLOR_W{1'b0}};
      blue_r    <= (active_s && col_s[0]) ? {COLOR_W{1'b1}} : {COLOR_W{1'b0}};
    end
  end

  assign vga.x_valid     = x_valid_r;
  assign vga.y_valid     = y_valid_r;
  assign vga.red_out     = red_r;
  assign vga.green_out   = green_r;
  assign vga.blue_out    = blue_r;
  assign vga.bt          = bt_r;
  assign vga.rx_valid    = rx_valid_r;
  assign vga.rx_err      = rx_err_r;
  assign vga.frame_start = frame_start_r;

endmodule

// File: doc/bt_vga_screen.md
Name: bt_vga_screen

Overview:
- Parametrised successor to the fixed-timing Bluetooth/VGA screen block.
- Receives 8N1 serial bytes from the Bluetooth module, decodes each byte into a display mode and colour, and generates VGA sync plus a test pattern.
- Timing, colour depth, baud rate and pattern geometry are all parameters.
- New command is applied only at a frame boundary, so the picture never tears.

Parameters:
- CLKS_PER_BIT, 10417, system clocks per UART bit (100 MHz / 9600 baud); must be >= 4.
- PIX_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz).
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal timing in pixels.
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical timing in lines.
- SYNC_POL, 0, sync active level (0 = active-low) for both syncs.
- COLOR_W, 4, bits per colour channel.
- CHECK_LOG2, 5, checkerboard square size = 2^CHECK_LOG2 pixels.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- get_bluetooth  in  1  serial RX line, idles high, asynchronous to clk
- x_valid  out  1  horizontal sync
- y_valid  out  1  vertical sync
- red_out  out  COLOR_W  red channel
- green_out  out  COLOR_W  green channel
- blue_out  out  COLOR_W  blue channel
- bt  out  8  last accepted byte
- rx_valid  out  1  one-clk pulse when bt updates
- rx_err  out  1  one-clk pulse on a discarded frame
- frame_start  out  1  one-clk pulse at pixel (0,0)

Behaviour:
- Reset (asynchronous, active-low):
  - x_valid = y_valid = ~SYNC_POL; all rgb = 0; bt = 0; rx_valid = rx_err = frame_start = 0.
  - Counters cleared; RX FSM to IDLE; active command = 0x00 (solid black).
  - Reset mid-byte or mid-frame abandons all state with no partial update.
- Synchroniser: get_bluetooth passes through 2 flops before use; the 2-clk delay is not counted in the bit timing below.
- RX FSM:
  - IDLE: a 1->0 on the synced line goes to START; bit counter = 0.
  - START: at CLKS_PER_BIT/2 clks, line still 0 -> DATA; line 1 -> IDLE (glitch, no rx_err).
  - DATA: sample every CLKS_PER_BIT clks, LSB first, 8 bits, then STOP (via PARITY if enabled).
  - STOP: sample after CLKS_PER_BIT. 1 -> bt <= byte, rx_valid pulse, pending command <= byte, pending flag set. 0 -> rx_err pulse, bt unchanged. Both return to IDLE.
  - A falling edge during STOP's sample clock is not a new start; detection resumes in IDLE.
- Pixel enable: pix_ce pulses once every PIX_DIV clks; all timing logic advances only on pix_ce.
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the four horizontal parameters, then wraps.
  - v_cnt increments on h_cnt wrap and wraps after V_TOTAL-1.
- Sync:
  - x_valid is active while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - y_valid follows the same rule with the vertical parameters.
- Frame boundary: on the pix_ce where the counters wrap to (0,0):
  - frame_start pulses.
  - If the pending flag is set, active command <= pending and the flag clears.
  - A byte landing on that same clk is deferred to the next frame.
  - Two bytes within one frame: the last one wins.
- Command decode (active byte):
  - [1:0] mode: 0 = solid, 1 = 8 vertical bars, 2 = 8 horizontal bars, 3 = checkerboard.
  - [4:2] colour {R,G,B}; each set bit drives its channel at full scale (all ones), a clear bit drives 0.
  - [7:5] ignored.
- Patterns:
  - Vertical bars: bar i = h_cnt / (H_ACTIVE/8), clamped to 7; bar colour = {i[2],i[1],i[0]}; byte colour bits are ignored.
  - Horizontal bars: same rule using v_cnt and V_ACTIVE.
  - Checkerboard: h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2] = 1 gives the command colour, otherwise black.
- Output registering:
  - rgb, x_valid and y_valid are registered together, one pixel (PIX_DIV clks) after the counter value; sync and colour stay aligned.
  - rgb = 0 whenever h_cnt >= H_ACTIVE or v_cnt >= V_ACTIVE.

Optional Feature:
- Macro: BT_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted after DATA and samples one extra bit.
  - The byte is accepted only if data XOR parity bit = 0 (even parity).
  - A mismatch pulses rx_err and discards the byte; the stop bit is still required.
- Undefined: 8N1 framing, no parity state; rx_err comes only from a bad stop bit.

Test Plan:
- Small timing: H 8/2/2/4, V 4/1/1/2, PIX_DIV = 1, after reset -> x_valid low for h_cnt 10..11 every 16 clks; y_valid low for lines 5; frame_start every 128 clks; rgb = 0 throughout (command 0x00).
- CLKS_PER_BIT = 16, send 0x1C (solid white) -> rx_valid pulse, bt = 0x1C; rgb stays 0 until the next frame_start, then 0xF on all channels in active area and 0 in blanking.
- Send 0x01, H_ACTIVE = 8 -> pixel x shows colour {x[2],x[1],x[0]}, e.g. x = 5 gives R = F, G = 0, B = F.
- Send 0x03 then 0x10 within the same frame -> next frame is solid red; checkerboard never shown.
- Stop bit driven 0 -> rx_err pulse, bt unchanged; 0.3-bit low glitch on idle line -> no rx_valid, no rx_err.
- Assert rst_n mid-DATA and mid-frame -> outputs return to reset values immediately; a clean byte sent after release is received correctly.
